// File: rtl/md5_pkg.sv
// Shared definitions for the brute-force MD5 search controller.
package md5_pkg;

    localparam int unsigned MD5_MSG_W   = 128;
    localparam int unsigned MD5_WIDTH_W = 8;

    localparam logic [7:0] CHAR_MIN_DEF = 8'h61;
    localparam logic [7:0] CHAR_MAX_DEF = 8'h7a;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StIssue,
        StWaitDig,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/md5_cand_counter.sv
// Odometer over up to MAX_LEN characters; rightmost character (index 0) turns fastest.
module md5_cand_counter
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 8,
    parameter logic [7:0]  CHAR_MIN = CHAR_MIN_DEF,
    parameter logic [7:0]  CHAR_MAX = CHAR_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_i,
    input  logic                   adv_i,
    output logic [MD5_MSG_W-1:0]   msg_o,
    output logic [MD5_WIDTH_W-1:0] width_o,
    output logic                   last_o
);

    localparam int unsigned LEN_W = 5;

    logic [MAX_LEN-1:0][7:0] chars_q, chars_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    carry;

    always_comb begin
        chars_d = chars_q;
        len_d   = len_q;
        carry   = 1'b0;
        if (clr_i) begin
            chars_d = {MAX_LEN{CHAR_MIN}};
            len_d   = LEN_W'(1);
        end else if (adv_i) begin
            carry = 1'b1;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (carry && (LEN_W'(i) < len_q)) begin
                    if (chars_q[i] == CHAR_MAX) begin
                        chars_d[i] = CHAR_MIN;
                    end else begin
                        chars_d[i] = chars_q[i] + 8'd1;
                        carry      = 1'b0;
                    end
                end
            end
            // Carry out of the leftmost char opens the next length, all at CHAR_MIN.
            if (carry && (len_q < LEN_W'(MAX_LEN))) begin
                len_d   = len_q + LEN_W'(1);
                chars_d = {MAX_LEN{CHAR_MIN}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chars_q <= '0;
            len_q   <= '0;
        end else begin
            chars_q <= chars_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        msg_o  = '0;
        last_o = (len_q == LEN_W'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_q) begin
                msg_o[8*i +: 8] = chars_q[i];
            end
            if (chars_q[i] != CHAR_MAX) begin
                last_o = 1'b0;
            end
        end
    end

    assign width_o = {len_q, 3'b000};

endmodule

// File: rtl/md5_brute_ctrl.sv
// Brute-force candidate generator feeding an MD5 core and matching its digests against a target.
module md5_brute_ctrl
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 8,
    parameter logic [7:0]  CHAR_MIN = CHAR_MIN_DEF,
    parameter logic [7:0]  CHAR_MAX = CHAR_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [MD5_MSG_W-1:0]   target_digest,
    input  logic                   md5_ready,
    output logic [MD5_MSG_W-1:0]   md5_msg_in,
    output logic [MD5_WIDTH_W-1:0] md5_msg_in_width,
    output logic                   md5_msg_in_valid,
    input  logic [MD5_MSG_W-1:0]   md5_msg_output,
    input  logic                   md5_msg_out_valid,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [MD5_MSG_W-1:0]   match_msg,
    output logic [MD5_WIDTH_W-1:0] match_width,
    output logic [31:0]            attempt_count
);

    state_e                 state_q, state_d;
    logic [MD5_MSG_W-1:0]   target_q, target_d;
    logic [MD5_MSG_W-1:0]   digest_q, digest_d;
    logic [MD5_MSG_W-1:0]   match_msg_q, match_msg_d;
    logic [MD5_WIDTH_W-1:0] match_width_q, match_width_d;
    logic                   found_q, found_d;
    logic                   exhausted_q, exhausted_d;
    logic [31:0]            attempt_q, attempt_d;

    logic                   cand_clr, cand_adv, cand_last;
    logic [MD5_MSG_W-1:0]   cand_msg;
    logic [MD5_WIDTH_W-1:0] cand_width;

    md5_cand_counter #(
        .MAX_LEN  (MAX_LEN),
        .CHAR_MIN (CHAR_MIN),
        .CHAR_MAX (CHAR_MAX)
    ) u_cand (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cand_clr),
        .adv_i   (cand_adv),
        .msg_o   (cand_msg),
        .width_o (cand_width),
        .last_o  (cand_last)
    );

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        digest_d      = digest_q;
        match_msg_d   = match_msg_q;
        match_width_d = match_width_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        attempt_d     = attempt_q;
        cand_clr      = 1'b0;
        cand_adv      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d       = StWaitRdy;
                    target_d      = target_digest;
                    found_d       = 1'b0;
                    exhausted_d   = 1'b0;
                    attempt_d     = '0;
                    match_msg_d   = '0;
                    match_width_d = '0;
                    cand_clr      = 1'b1;
                end
            end
            StWaitRdy: if (md5_ready) state_d = StIssue;
            StIssue:   state_d = StWaitDig;
            StWaitDig: begin
                if (md5_msg_out_valid) begin
                    digest_d = md5_msg_output;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (attempt_q != 32'hFFFF_FFFF) attempt_d = attempt_q + 32'd1;
                // A match takes priority, so a hit on the final candidate reports found.
                if (digest_q == target_q) begin
                    found_d       = 1'b1;
                    match_msg_d   = cand_msg;
                    match_width_d = cand_width;
                    state_d       = StDone;
                end else if (cand_last) begin
                    exhausted_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cand_adv = 1'b1;
                    state_d  = StWaitRdy;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            target_q      <= '0;
            digest_q      <= '0;
            match_msg_q   <= '0;
            match_width_q <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            attempt_q     <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            digest_q      <= digest_d;
            match_msg_q   <= match_msg_d;
            match_width_q <= match_width_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            attempt_q     <= attempt_d;
        end
    end

    // The counter is frozen outside CHECK, so msg/width stay stable across ISSUE..CHECK.
    assign md5_msg_in       = cand_msg;
    assign md5_msg_in_width = cand_width;
    assign md5_msg_in_valid = (state_q == StIssue) && !reset;
    assign busy             = (state_q != StIdle) && (state_q != StDone);
    assign found            = found_q;
    assign exhausted        = exhausted_q;
    assign match_msg        = match_msg_q;
    assign match_width      = match_width_q;
    assign attempt_count    = attempt_q;

endmodule

// File: tb/tb_md5_brute_ctrl.sv
// Bench for md5_brute_ctrl with a behavioural MD5 core model standing in for pancham.
module tb_md5_brute_ctrl;

    localparam int LAT    = 4;
    localparam int BUDGET = 20000;

    localparam logic [127:0] DIG_A   = 128'h0cc175b9c0f1b6a831c399e269772661;
    localparam logic [127:0] DIG_AB  = 128'h187ef4436122d1cc2f40dc2b92f0eba0;
    localparam logic [127:0] DIG_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start0 = 1'b0, start1 = 1'b0;
    logic [127:0] target = '0;
    logic         hold_low = 1'b0;
    logic         inj_valid = 1'b0;
    logic [127:0] inj_digest = '0;

    logic         md5_ready, md5_msg_out_valid;
    logic [127:0] md5_msg_output;
    logic         mdl_busy, mdl_out_valid;
    logic [127:0] mdl_digest;
    int           mdl_cnt;

    logic [127:0] d0_msg, d1_msg, d0_match, d1_match;
    logic [7:0]   d0_width, d1_width, d0_mwidth, d1_mwidth;
    logic         d0_valid, d1_valid, d0_busy, d1_busy, d0_found, d1_found, d0_exh, d1_exh;
    logic [31:0]  d0_att, d1_att;

    int           strobe_cnt = 0;
    logic [127:0] strobe_msg = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    md5_brute_ctrl #(.MAX_LEN(8)) u_dut (
        .clk (clk), .reset (reset), .start (start0), .target_digest (target),
        .md5_ready (md5_ready), .md5_msg_in (d0_msg), .md5_msg_in_width (d0_width),
        .md5_msg_in_valid (d0_valid), .md5_msg_output (md5_msg_output),
        .md5_msg_out_valid (md5_msg_out_valid), .busy (d0_busy), .found (d0_found),
        .exhausted (d0_exh), .match_msg (d0_match), .match_width (d0_mwidth),
        .attempt_count (d0_att)
    );

    md5_brute_ctrl #(.MAX_LEN(1)) u_dut_len1 (
        .clk (clk), .reset (reset), .start (start1), .target_digest (target),
        .md5_ready (md5_ready), .md5_msg_in (d1_msg), .md5_msg_in_width (d1_width),
        .md5_msg_in_valid (d1_valid), .md5_msg_output (md5_msg_output),
        .md5_msg_out_valid (md5_msg_out_valid), .busy (d1_busy), .found (d1_found),
        .exhausted (d1_exh), .match_msg (d1_match), .match_width (d1_mwidth),
        .attempt_count (d1_att)
    );

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Single-block MD5 of a right-justified string of width_bits/8 characters.
    function automatic logic [127:0] md5_ref(input logic [127:0] msg, input logic [7:0] width_bits);
        logic [7:0]  blk [64];
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f;
        int          nb, g, s;
        nb = int'(width_bits) / 8;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int j = 0; j < nb; j++) blk[j] = msg[8*(nb-1-j) +: 8];
        blk[nb] = 8'h80;
        blk[56] = width_bits;
        for (int w = 0; w < 16; w++) m[w] = {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
            f = f + a + K_TAB[i] + m[g];
            s = S_TAB[(i/16)*4 + i%4];
            a = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
        end
        a = a + 32'h67452301; b = b + 32'hefcdab89;
        c = c + 32'h98badcfe; d = d + 32'h10325476;
        return {bswap(a), bswap(b), bswap(c), bswap(d)};
    endfunction

    // MD5 core model: accepts one message when ready, answers LAT cycles later.
    always @(posedge clk) begin
        if (reset) begin
            mdl_busy      <= 1'b0;
            mdl_out_valid <= 1'b0;
            mdl_cnt       <= 0;
            mdl_digest    <= '0;
        end else begin
            mdl_out_valid <= 1'b0;
            if (!mdl_busy && (d0_valid || d1_valid)) begin
                mdl_busy   <= 1'b1;
                mdl_cnt    <= LAT;
                mdl_digest <= d0_valid ? md5_ref(d0_msg, d0_width) : md5_ref(d1_msg, d1_width);
            end else if (mdl_busy) begin
                if (mdl_cnt == 1) begin
                    mdl_out_valid <= 1'b1;
                    mdl_busy      <= 1'b0;
                end
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    assign md5_ready         = !mdl_busy && !hold_low;
    assign md5_msg_out_valid = mdl_out_valid || inj_valid;
    assign md5_msg_output    = inj_valid ? inj_digest : mdl_digest;

    always @(negedge clk) begin
        if (d0_valid) begin
            strobe_cnt <= strobe_cnt + 1;
            strobe_msg <= d0_msg;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic run0(input string tag, input logic [127:0] tgt);
        int n;
        target = tgt;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        target = '1;
        n = 0;
        while (d0_busy && n < BUDGET) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, d0_busy, 0);
    endtask

    task automatic check_hit(input string tag, input logic [127:0] msg, input logic [7:0] w,
                             input logic [31:0] att);
        check_eq({tag, "_found"}, d0_found, 1);
        check_eq({tag, "_exh"}, d0_exh, 0);
        check_eq({tag, "_match"}, d0_match, msg);
        check_eq({tag, "_mwidth"}, d0_mwidth, w);
        check_eq({tag, "_att"}, d0_att, att);
    endtask

    initial begin
        int s0, n;
        repeat (3) tick();
        check_eq("rst_busy", d0_busy, 0);
        check_eq("rst_found", d0_found, 0);
        check_eq("rst_msg", d0_msg, 0);
        check_eq("rst_width", d0_width, 0);
        check_eq("rst_att", d0_att, 0);
        reset = 1'b0;
        tick();

        run0("a", DIG_A);
        check_hit("a", 128'h61, 8'h08, 32'd1);
        run0("ab", DIG_AB);
        check_hit("ab", 128'h6162, 8'h10, 32'd28);
        run0("abc", DIG_ABC);
        check_hit("abc", 128'h616263, 8'h18, 32'd731);

        // Single-character search space with an unreachable target.
        target = '0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (d1_busy && n < BUDGET) begin
            tick();
            n++;
        end
        check_eq("len1_busy", d1_busy, 0);
        check_eq("len1_exh", d1_exh, 1);
        check_eq("len1_found", d1_found, 0);
        check_eq("len1_att", d1_att, 26);

        // Stall on ready low; stray digest and second start must both be ignored.
        hold_low = 1'b1;
        s0 = strobe_cnt;
        target = DIG_A;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (10) tick();
        inj_digest = DIG_A;
        inj_valid  = 1'b1;
        tick();
        inj_valid  = 1'b0;
        target = DIG_AB;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (37) tick();
        check_eq("stall_strobes", 128'(strobe_cnt - s0), 0);
        check_eq("stall_busy", d0_busy, 1);
        check_eq("stall_att", d0_att, 0);
        check_eq("stall_found", d0_found, 0);
        hold_low = 1'b0;
        n = 0;
        while (d0_busy && n < BUDGET) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check_eq("rel_strobes", 128'(strobe_cnt - s0), 1);
        check_eq("rel_msg", strobe_msg, 128'h61);
        check_hit("rel", 128'h61, 8'h08, 32'd1);

        // Start and reset together: reset wins.
        reset  = 1'b1;
        start0 = 1'b1;
        tick();
        reset  = 1'b0;
        start0 = 1'b0;
        repeat (3) tick();
        check_eq("coll_busy", d0_busy, 0);
        check_eq("coll_found", d0_found, 0);

        // Reset while waiting on a digest mid-search.
        target = DIG_ABC;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (d0_att < 100 && n < BUDGET) begin
            tick();
            n++;
        end
        s0 = strobe_cnt;
        n = 0;
        while (strobe_cnt == s0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        check_eq("mid_busy", d0_busy, 1);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_busy", d0_busy, 0);
        check_eq("mid_rst_valid", d0_valid, 0);
        check_eq("mid_rst_msg", d0_msg, 0);
        check_eq("mid_rst_width", d0_width, 0);
        check_eq("mid_rst_att", d0_att, 0);
        check_eq("mid_rst_flags", {d0_found, d0_exh}, 0);
        check_eq("mid_rst_match", {d0_match, d0_mwidth}, 0);
        reset = 1'b0;
        tick();
        run0("abc2", DIG_ABC);
        check_hit("abc2", 128'h616263, 8'h18, 32'd731);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
